mips_cpu_load_unit: RTL and testbench

- Data-memory load sequencer that sits directly upstream of the writeback select mux.
- Accepts a load request from the execute stage and issues one Avalon-style read (address, read, byteenable, waitrequest).
- Aligns and extends the returned word (LB/LBU/LH/LHU/LW), or merges it with the old rt value (LWL/LWR).
- Presents the result as load_data plus an islwlr flag for writeback.

---
 rtl/mips_cpu_pkg.sv | 38 +++
 rtl/mips_cpu_load_align.sv | 37 +++
 rtl/mips_cpu_load_unit.sv | 133 +++++++++++++
 tb/tb_mips_cpu_load_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS load path: load opcodes, load-sequencer states,
// and the alignment-check helpers.
package mips_cpu_pkg;

  typedef enum logic [2:0] {
    LD_LB      = 3'b000,
    LD_LH      = 3'b001,
    LD_LWL     = 3'b010,
    LD_LW      = 3'b011,
    LD_LBU     = 3'b100,
    LD_LHU     = 3'b101,
    LD_LWR     = 3'b110,
    LD_ILLEGAL = 3'b111
  } load_type_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } load_state_t;

  localparam logic [3:0] LOAD_BYTEENABLE_ALL = 4'b1111;

  // True when the request must complete without touching the bus.
  function automatic logic is_misaligned(load_type_t t, logic [1:0] k);
    case (t)
      LD_LH, LD_LHU: return k[0];
      LD_LW:         return k != 2'b00;
      LD_ILLEGAL:    return 1'b1;
      default:       return 1'b0;
    endcase
  endfunction

  function automatic logic is_lwlr(load_type_t t);
    return (t == LD_LWL) || (t == LD_LWR);
  endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Combinational byte/halfword extract with sign/zero extension, and the
// LWL/LWR merge of the returned word into the old rt value.
module mips_cpu_load_align
  import mips_cpu_pkg::*;
(
  input  load_type_t  ld_type,
  input  logic [1:0]  k,
  input  logic [31:0] w,
  input  logic [31:0] rt_old,
  output logic [31:0] data_c
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic [4:0]  lsh_c;
  logic [4:0]  rsh_c;

  always_comb begin
    byte_c = 8'(w >> {k, 3'b000});
    half_c = k[1] ? w[31:16] : w[15:0];
    // 8*(3-k) equals {~k,000} for a 2-bit k
    lsh_c  = {~k, 3'b000};
    rsh_c  = {k, 3'b000};
    data_c = '0;
    case (ld_type)
      LD_LB:   data_c = {{24{byte_c[7]}}, byte_c};
      LD_LBU:  data_c = {24'h000000, byte_c};
      LD_LH:   data_c = {{16{half_c[15]}}, half_c};
      LD_LHU:  data_c = {16'h0000, half_c};
      LD_LW:   data_c = w;
      LD_LWL:  data_c = (w << lsh_c) | (rt_old & ~(32'hFFFF_FFFF << lsh_c));
      LD_LWR:  data_c = (w >> rsh_c) | (rt_old & ~(32'hFFFF_FFFF >> rsh_c));
      default: data_c = '0;
    endcase
  end

endmodule

// File: rtl/mips_cpu_load_unit.sv
// Data-memory load sequencer: one Avalon read per request, result aligned for
// writeback. Define LOAD_TIMEOUT_EN to abort reads stalled TIMEOUT_CYCLES cycles.
module mips_cpu_load_unit
  import mips_cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  ld_type,
  input  logic [31:0] addr,
  input  logic [31:0] rt_old,
  output logic [31:0] avm_address,
  output logic        avm_read,
  output logic [3:0]  avm_byteenable,
  input  logic [31:0] avm_readdata,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        islwlr,
  output logic        addr_error,
  output logic        bus_error
);

  load_state_t state, state_next;
  load_type_t  ld_type_c, ld_type_q;
  logic [1:0]  k_q;
  logic [31:0] rt_q;
  logic [31:0] align_c;
  logic        accept_c, bad_c, ack_c, timeout_c;

  assign avm_byteenable = LOAD_BYTEENABLE_ALL;
  assign ld_type_c      = load_type_t'(ld_type);

  mips_cpu_load_align u_align (
    .ld_type (ld_type_q),
    .k       (k_q),
    .w       (avm_readdata),
    .rt_old  (rt_q),
    .data_c  (align_c)
  );

`ifdef LOAD_TIMEOUT_EN
  localparam int unsigned CNT_W =
    ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] wait_cnt;

  // Counts stalled REQ cycles; the last allowed stall aborts the read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if (accept_c)
      wait_cnt <= '0;
    else if (state == ST_REQ && avm_waitrequest)
      wait_cnt <= wait_cnt + CNT_W'(1);
  end

  assign timeout_c = (state == ST_REQ) && avm_waitrequest &&
                     (wait_cnt >= CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
`endif

  always_comb begin
    state_next = state;
    accept_c   = 1'b0;
    bad_c      = 1'b0;
    ack_c      = 1'b0;
    case (state)
      ST_IDLE: begin
        accept_c = start;
        bad_c    = start && is_misaligned(ld_type_c, addr[1:0]);
        if (start)
          state_next = bad_c ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        ack_c = !avm_waitrequest;
        if (ack_c || timeout_c)
          state_next = ST_DONE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      avm_read    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      avm_address <= '0;
      ld_type_q   <= LD_LB;
      k_q         <= '0;
      rt_q        <= '0;
      load_data   <= '0;
      islwlr      <= 1'b0;
      addr_error  <= 1'b0;
      bus_error   <= 1'b0;
    end else begin
      state    <= state_next;
      avm_read <= (state_next == ST_REQ);
      busy     <= (state_next != ST_IDLE);
      done     <= (state_next == ST_DONE);
      if (accept_c) begin
        avm_address <= {addr[31:2], 2'b00};
        ld_type_q   <= ld_type_c;
        k_q         <= addr[1:0];
        rt_q        <= rt_old;
      end
      // Result flags change only on entry to DONE
      if (bad_c) begin
        islwlr     <= 1'b0;
        addr_error <= 1'b1;
        bus_error  <= 1'b0;
      end else if (ack_c) begin
        load_data  <= align_c;
        islwlr     <= is_lwlr(ld_type_q);
        addr_error <= 1'b0;
        bus_error  <= 1'b0;
      end else if (timeout_c) begin
        islwlr     <= is_lwlr(ld_type_q);
        addr_error <= 1'b0;
        bus_error  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips_cpu_load_unit.sv
// Directed self-checking bench for mips_cpu_load_unit; the timeout scenario
// follows LOAD_TIMEOUT_EN.
module tb_mips_cpu_load_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  ld_type;
  logic [31:0] addr;
  logic [31:0] rt_old;
  logic [31:0] avm_address;
  logic        avm_read;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        islwlr;
  logic        addr_error;
  logic        bus_error;

  int checks = 0;
  int errors = 0;

  mips_cpu_load_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .ld_type         (ld_type),
    .addr            (addr),
    .rt_old          (rt_old),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_byteenable  (avm_byteenable),
    .avm_readdata    (avm_readdata),
    .avm_waitrequest (avm_waitrequest),
    .busy            (busy),
    .done            (done),
    .load_data       (load_data),
    .islwlr          (islwlr),
    .addr_error      (addr_error),
    .bus_error       (bus_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a one-cycle start; returns just after the edge that sampled it.
  task automatic issue(input logic [2:0] t, input logic [31:0] a, input logic [31:0] rt);
    ld_type = t;
    addr    = a;
    rt_old  = rt;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; ld_type = 3'b000; addr = '0; rt_old = '0;
    avm_readdata = '0; avm_waitrequest = 1'b0;
    step(); step();
    checks++;
    if ({avm_read, busy, done, islwlr, addr_error, bus_error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b expected 000000",
               {avm_read, busy, done, islwlr, addr_error, bus_error});
    end
    checks++;
    if (load_data !== 32'h0 || avm_address !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: load_data %h addr %h expected 0", load_data, avm_address);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_lw();
    avm_readdata = 32'hDEAD_BEEF; avm_waitrequest = 1'b0;
    issue(3'b011, 32'h0000_1000, 32'h0);
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h0000_1000 || avm_byteenable !== 4'b1111
        || busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL lw_req: read %b addr %h be %b busy %b done %b expected 1 00001000 1111 1 0",
               avm_read, avm_address, avm_byteenable, busy, done);
    end
    step();
    checks++;
    if (done !== 1'b1 || avm_read !== 1'b0 || load_data !== 32'hDEAD_BEEF || islwlr !== 1'b0) begin
      errors++;
      $display("FAIL lw_done: done %b read %b data %h islwlr %b expected 1 0 deadbeef 0",
               done, avm_read, load_data, islwlr);
    end
    step();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL lw_idle: done %b busy %b expected 0 0", done, busy);
    end
  endtask

  task automatic test_byte_wait(input logic [2:0] t, input logic [31:0] exp);
    int reads;
    reads = 0;
    avm_readdata = 32'h80FF_1234; avm_waitrequest = 1'b1;
    issue(t, 32'h0000_1003, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (avm_read === 1'b1) reads++;
      if (i == 3) avm_waitrequest = 1'b0;
      step();
    end
    checks++;
    if (reads != 4 || avm_read !== 1'b0 || done !== 1'b1) begin
      errors++;
      $display("FAIL byte_wait_read: read cycles %0d read %b done %b expected 4 0 1",
               reads, avm_read, done);
    end
    checks++;
    if (load_data !== exp) begin
      errors++;
      $display("FAIL byte_data: got %h expected %h", load_data, exp);
    end
    step();
  endtask

  task automatic test_lwlr(input logic [2:0] t, input logic [31:0] exp);
    avm_readdata = 32'h4433_2211; avm_waitrequest = 1'b0;
    issue(t, 32'h0000_2001, 32'hAABB_CCDD);
    step();
    checks++;
    if (done !== 1'b1 || load_data !== exp || islwlr !== 1'b1 || avm_address !== 32'h0000_2000) begin
      errors++;
      $display("FAIL lwlr: done %b data %h islwlr %b addr %h expected 1 %h 1 00002000",
               done, load_data, islwlr, avm_address, exp);
    end
    step();
  endtask

  task automatic test_misaligned(input logic [2:0] t, input logic [31:0] a, input logic [31:0] old);
    avm_readdata = 32'h1111_1111; avm_waitrequest = 1'b0;
    issue(t, a, 32'h0);
    checks++;
    if (done !== 1'b1 || avm_read !== 1'b0 || addr_error !== 1'b1 || load_data !== old
        || islwlr !== 1'b0) begin
      errors++;
      $display("FAIL misaligned_%h: done %b read %b aerr %b data %h islwlr %b expected 1 0 1 %h 0",
               a, done, avm_read, addr_error, load_data, islwlr, old);
    end
    step();
    checks++;
    if (busy !== 1'b0 || avm_read !== 1'b0 || addr_error !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_after: busy %b read %b aerr %b expected 0 0 1",
               busy, avm_read, addr_error);
    end
  endtask

  task automatic test_back_to_back();
    avm_readdata = 32'h0102_0304; avm_waitrequest = 1'b1;
    issue(3'b011, 32'h0000_4000, 32'h0);
    issue(3'b000, 32'h0000_5001, 32'h0);
    checks++;
    if (avm_read !== 1'b1 || avm_address !== 32'h0000_4000) begin
      errors++;
      $display("FAIL busy_start: read %b addr %h expected 1 00004000", avm_read, avm_address);
    end
    avm_waitrequest = 1'b0;
    step();
    checks++;
    if (done !== 1'b1 || load_data !== 32'h0102_0304 || addr_error !== 1'b0) begin
      errors++;
      $display("FAIL busy_done: done %b data %h aerr %b expected 1 01020304 0",
               done, load_data, addr_error);
    end
    step();
    checks++;
    if (avm_read !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_no_queue: read %b busy %b expected 0 0", avm_read, busy);
    end
  endtask

  task automatic test_reset_mid_req();
    avm_waitrequest = 1'b1;
    issue(3'b011, 32'h0000_6000, 32'h0);
    checks++;
    if (avm_read !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_read: got %b expected 1", avm_read);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (avm_read !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || load_data !== 32'h0) begin
      errors++;
      $display("FAIL async_reset: read %b busy %b done %b data %h expected 0 0 0 0",
               avm_read, busy, done, load_data);
    end
    step();
    reset = 1'b0;
    step();
    avm_readdata = 32'h9ABC_0000; avm_waitrequest = 1'b0;
    issue(3'b101, 32'h0000_3002, 32'h0);
    step();
    checks++;
    if (done !== 1'b1 || load_data !== 32'h0000_9ABC || avm_address !== 32'h0000_3000) begin
      errors++;
      $display("FAIL lhu_after_reset: done %b data %h addr %h expected 1 00009abc 00003000",
               done, load_data, avm_address);
    end
    step();
  endtask

  task automatic test_timeout();
    int reads;
    reads = 0;
    avm_waitrequest = 1'b1;
    issue(3'b011, 32'h0000_7000, 32'h0);
`ifdef LOAD_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      if (avm_read === 1'b1) reads++;
      step();
    end
    checks++;
    if (reads != 4 || avm_read !== 1'b0 || done !== 1'b1 || bus_error !== 1'b1
        || load_data !== 32'h0000_9ABC) begin
      errors++;
      $display("FAIL timeout: reads %0d read %b done %b berr %b data %h expected 4 0 1 1 00009abc",
               reads, avm_read, done, bus_error, load_data);
    end
    step();
`else
    for (int i = 0; i < 100; i++) begin
      if (avm_read === 1'b1) reads++;
      step();
    end
    checks++;
    if (reads != 100 || busy !== 1'b1 || avm_read !== 1'b1 || bus_error !== 1'b0) begin
      errors++;
      $display("FAIL no_timeout: reads %0d busy %b read %b berr %b expected 100 1 1 0",
               reads, busy, avm_read, bus_error);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
`endif
    avm_waitrequest = 1'b0;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_byte_wait(3'b000, 32'hFFFF_FF80);
    test_byte_wait(3'b100, 32'h0000_0080);
    test_lwlr(3'b010, 32'h2211_CCDD);
    test_lwlr(3'b110, 32'hAA44_3322);
    test_misaligned(3'b001, 32'h0000_3001, 32'hAA44_3322);
    test_misaligned(3'b011, 32'h0000_3002, 32'hAA44_3322);
    test_misaligned(3'b111, 32'h0000_3000, 32'hAA44_3322);
    test_back_to_back();
    test_reset_mid_req();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
